pcileech_com_tx64to32: RTL

- 64→32-bit transmit serializer. It is the sending end of the COM 32→64 packer protocol.
- Accepts 64-bit words from the FIFO-side core and emits 32-bit dwords, upper dword first, toward a 32-bit link. Targets are FPGA-to-FPGA COM links and loopback/self-test of the COM RX path.
- Inserts resync pairs (two consecutive magic dwords) after reset, periodically, and on request, so the far-end packer realigns its 32→64 phase.

---
 rtl/pcileech_com_pkg.sv | 16 +
 rtl/pcileech_com_tx64to32.sv | 90 +++++++++
 2 files changed

// File: rtl/pcileech_com_pkg.sv
// pcileech_com_pkg: shared constants and types for the COM link serializer/packer pair.
package pcileech_com_pkg;

    localparam logic [31:0] COM_MAGIC = 32'h66665555;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC0,
        S_SYNC1,
        S_HI,
        S_LO
    } com_tx_state_t;

    typedef logic [63:0] com_qword_t;

endpackage

// File: rtl/pcileech_com_tx64to32.sv
// pcileech_com_tx64to32: 64->32 bit COM transmit serializer, upper dword first,
// with magic resync pairs after reset, periodically and on request.
module pcileech_com_tx64to32
    import pcileech_com_pkg::*;
#(
    parameter logic [31:0] MAGIC           = COM_MAGIC,
    parameter int          RESYNC_INTERVAL = 256,
    parameter int          CNT_W           = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [63:0]      din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic [31:0]      dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    input  logic             resync_req,
    output logic             busy,
    output logic             magic_hazard,
    output logic [CNT_W-1:0] cnt_words
);

    localparam int IW = (RESYNC_INTERVAL > 0) ? $clog2(RESYNC_INTERVAL + 1) : 1;

    com_tx_state_t state, state_nxt;
    com_qword_t    hold;
    logic          sync_pending, sync_nxt, last_was_magic;
    logic [IW-1:0] ivl_cnt, ivl_inc;
    logic          dout_xfer, din_xfer, ivl_hit, in_sync, in_payload, dout_is_magic;

    assign in_sync       = (state == S_SYNC0) || (state == S_SYNC1);
    assign in_payload    = (state == S_HI) || (state == S_LO);
    assign dout_valid    = state != S_IDLE;
    assign dout          = in_sync ? MAGIC : (state == S_HI) ? hold[63:32] : (state == S_LO) ? hold[31:0] : '0;
    assign din_ready     = ~sync_pending & ((state == S_IDLE) | ((state == S_LO) & dout_ready));
    assign dout_xfer     = dout_valid & dout_ready;
    assign din_xfer      = din_valid & din_ready;
    assign busy          = dout_valid | sync_pending;
    assign dout_is_magic = dout == MAGIC;
    assign ivl_inc       = ivl_cnt + IW'(1);
    assign ivl_hit       = (RESYNC_INTERVAL != 0) && din_xfer && (ivl_inc == IW'(RESYNC_INTERVAL));

    // A pending pair is only honoured at a word boundary, so HI always runs straight into LO.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  state_nxt = sync_pending ? S_SYNC0 : din_xfer ? S_HI : S_IDLE;
            S_SYNC0: state_nxt = dout_xfer ? S_SYNC1 : S_SYNC0;
            S_SYNC1: state_nxt = dout_xfer ? S_IDLE : S_SYNC1;
            S_HI:    state_nxt = dout_xfer ? S_LO : S_HI;
            S_LO:    state_nxt = !dout_xfer ? S_LO : din_xfer ? S_HI : sync_pending ? S_SYNC0 : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Requests arriving while a pair is already on the wire fold into that pair.
    always_comb begin
        sync_nxt = sync_pending;
        if ((state == S_SYNC1) && dout_xfer)
            sync_nxt = 1'b0;
        if ((resync_req && !in_sync) || ivl_hit)
            sync_nxt = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            hold           <= '0;
            sync_pending   <= 1'b1;
            ivl_cnt        <= '0;
            last_was_magic <= 1'b0;
            magic_hazard   <= 1'b0;
            cnt_words      <= '0;
        end else begin
            state        <= state_nxt;
            sync_pending <= sync_nxt;
            magic_hazard <= dout_xfer & in_payload & last_was_magic & dout_is_magic;
            if (din_xfer) begin
                hold    <= din;
                ivl_cnt <= ivl_hit ? '0 : ivl_inc;
            end
            if (dout_xfer)
                last_was_magic <= in_payload & dout_is_magic;
            if (dout_xfer && (state == S_LO))
                cnt_words <= cnt_words + CNT_W'(1);
        end
    end

endmodule
